rsp_dist: RTL

//  - Response distributor directly downstream of the MC response XBAR FIFO.
//  - Consumes active-low per-port response requests plus the shared last/rdctl/data bus.
//  - Returns same-cycle per-port grants gated by per-port credits.
//  - Drives a registered valid/data interface to each of NPORTS consumer ports, which return

---
 rtl/cae_rsp_pkg.sv | 8 +
 rtl/rsp_credit_ctr.sv | 30 +++
 rtl/rsp_dist.sv | 110 +++++++++++
 3 files changed

// File: rtl/cae_rsp_pkg.sv
// Shared widths and bit positions for the MC response path.
package cae_rsp_pkg;
    localparam int RSP_RDCTL_W  = 32;
    localparam int RSP_DATA_W   = 64;
    localparam int RSP_PORT_LSB = 24;
    localparam int RSP_PORT_MSB = 31;
    localparam int MAX_PORTS    = 8;
endpackage

// File: rtl/rsp_credit_ctr.sv
// Per-port credit counter: spends one credit per grant, regains one per return,
// saturating at CREDITS and flagging any return that would push it past full.
module rsp_credit_ctr #(
    parameter int CREDITS = 4,
    parameter int CRED_W  = 4
) (
    input  logic clk167,
    input  logic reset167_,
    input  logic grant,
    input  logic ret,
    output logic has_credit,
    output logic overflow
);
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDITS);

    logic [CRED_W-1:0] cred;

    assign has_credit = (cred != '0);
    assign overflow   = ret & ~grant & (cred == CRED_FULL);

    always_ff @(posedge clk167 or negedge reset167_) begin
        if (!reset167_) begin
            cred <= CRED_FULL;
        end else if (grant && !ret) begin
            cred <= cred - 1'b1;
        end else if (ret && !grant && (cred != CRED_FULL)) begin
            cred <= cred + 1'b1;
        end
    end
endmodule

// File: rtl/rsp_dist.sv
// Response distributor: lowest-index credit-gated grant, registered per-port delivery.
// Optional RSP_DIST_PERF_EN adds per-port delivery/stall counters with a select port.
module rsp_dist
    import cae_rsp_pkg::*;
#(
    parameter int NPORTS  = 8,
    parameter int CREDITS = 4,
    parameter int CRED_W  = 4
) (
    input  logic                   clk167,
    input  logic                   reset167_,
    input  logic [NPORTS-1:0]      p_rsp_,
    input  logic                   rsp_last,
    input  logic [RSP_RDCTL_W-1:0] rsp_rdctl,
    input  logic [RSP_DATA_W-1:0]  rsp_data,
    output logic [NPORTS-1:0]      p_grant,
    output logic [NPORTS-1:0]      o_vld,
    output logic                   o_last,
    output logic [RSP_RDCTL_W-1:0] o_rdctl,
    output logic [RSP_DATA_W-1:0]  o_data,
    input  logic [NPORTS-1:0]      p_cred_ret,
`ifdef RSP_DIST_PERF_EN
    input  logic [2:0]             perf_sel,
    output logic [31:0]            perf_dlv,
    output logic [31:0]            perf_stl,
`endif
    output logic                   cred_alarm,
    output logic                   multi_alarm
);
    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] lowest;
    logic [NPORTS-1:0] has_credit;
    logic [NPORTS-1:0] overflow;
    logic              multi_req;

    // Reset gates the request vector so no grant can escape while in reset.
    assign req       = ~p_rsp_ & {NPORTS{reset167_}};
    assign lowest    = req & (~req + NPORTS'(1));
    assign multi_req = ((req & (req - NPORTS'(1))) != '0);
    assign p_grant   = lowest & has_credit;

    for (genvar i = 0; i < NPORTS; i++) begin : g_cred
        rsp_credit_ctr #(
            .CREDITS (CREDITS),
            .CRED_W  (CRED_W)
        ) u_ctr (
            .clk167     (clk167),
            .reset167_  (reset167_),
            .grant      (p_grant[i]),
            .ret        (p_cred_ret[i]),
            .has_credit (has_credit[i]),
            .overflow   (overflow[i])
        );
    end

    always_ff @(posedge clk167 or negedge reset167_) begin
        if (!reset167_) begin
            o_vld   <= '0;
            o_last  <= 1'b0;
            o_rdctl <= '0;
            o_data  <= '0;
        end else begin
            o_vld <= p_grant;
            if (p_grant != '0) begin
                o_last  <= rsp_last;
                o_rdctl <= rsp_rdctl;
                o_data  <= rsp_data;
            end
        end
    end

    always_ff @(posedge clk167 or negedge reset167_) begin
        if (!reset167_) begin
            cred_alarm  <= 1'b0;
            multi_alarm <= 1'b0;
        end else begin
            cred_alarm  <= cred_alarm | (overflow != '0);
            multi_alarm <= multi_alarm | multi_req;
        end
    end

`ifdef RSP_DIST_PERF_EN
    // Counters are sized for MAX_PORTS so perf_sel indexes cleanly; unused ports stay 0.
    logic [MAX_PORTS-1:0] grant_pad;
    logic [MAX_PORTS-1:0] stall_pad;
    logic [31:0]          dlv_cnt [MAX_PORTS];
    logic [31:0]          stl_cnt [MAX_PORTS];

    assign grant_pad = MAX_PORTS'(p_grant);
    assign stall_pad = MAX_PORTS'(req & ~has_credit);

    always_ff @(posedge clk167 or negedge reset167_) begin
        if (!reset167_) begin
            for (int i = 0; i < MAX_PORTS; i++) begin
                dlv_cnt[i] <= '0;
                stl_cnt[i] <= '0;
            end
            perf_dlv <= '0;
            perf_stl <= '0;
        end else begin
            for (int i = 0; i < MAX_PORTS; i++) begin
                if (grant_pad[i]) dlv_cnt[i] <= dlv_cnt[i] + 32'd1;
                if (stall_pad[i]) stl_cnt[i] <= stl_cnt[i] + 32'd1;
            end
            perf_dlv <= dlv_cnt[perf_sel];
            perf_stl <= stl_cnt[perf_sel];
        end
    end
`endif
endmodule
